// File: rtl/lsu_dmem_port.sv
// Load/store unit between the core memory stage and word-addressed data memory.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module lsu_dmem_port #(
   parameter int unsigned ADDR_WORDS = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_we,
   output logic [31:0] mem_a,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [1:0] size,
                                            input logic uns, input logic [1:0] off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
         SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Replace one byte or half lane of a word already read from memory.
   function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [15:0] wdata,
                                              input logic [1:0] size, input logic [1:0] off);
      logic [31:0] r;
      r = word;
      case (size)
         SZ_BYTE: begin
            case (off)
               2'd0:    r[7:0]   = wdata[7:0];
               2'd1:    r[15:8]  = wdata[7:0];
               2'd2:    r[23:16] = wdata[7:0];
               default: r[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (off[1]) r[31:16] = wdata;
            else        r[15:0]  = wdata;
         end
         default: r = word;
      endcase
      return r;
   endfunction

   state_t      state_r, state_nxt_s;
   logic        we_r;
   logic [1:0]  size_r;
   logic        uns_r;
   logic [1:0]  off_r;
   logic [15:0] wdata_r;
   logic        mem_we_r, mem_we_nxt_s;
   logic [31:0] mem_a_r, mem_a_nxt_s;
   logic [31:0] mem_wd_r, mem_wd_nxt_s;
   logic        resp_valid_r, resp_valid_nxt_s;
   logic [31:0] resp_rdata_r, resp_rdata_nxt_s;
   logic        resp_err_r, resp_err_nxt_s;
   logic        accept_s;
   logic        misalign_s;
   logic        req_err_s;

   assign req_ready  = (state_r == IDLE) && !reset;
   assign accept_s   = req_valid && req_ready;
   assign mem_we     = mem_we_r && !reset;
   assign mem_a      = mem_a_r;
   assign mem_wd     = mem_wd_r;
   assign resp_valid = resp_valid_r;
   assign resp_rdata = resp_rdata_r;
   assign resp_err   = resp_err_r;

   // Classify the incoming request so faults can go straight to RESP.
   always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_s = ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
      misalign_s = 1'b0;
`endif
      req_err_s = (req_size == SZ_RSVD) ||
                  ({2'b00, req_addr[31:2]} >= 32'(ADDR_WORDS)) ||
                  misalign_s;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_r <= IDLE;
      else       state_r <= state_nxt_s;
   end

   // Next state and next values of the registered port outputs.
   always_comb begin
      state_nxt_s      = state_r;
      mem_we_nxt_s     = 1'b0;
      mem_a_nxt_s      = mem_a_r;
      mem_wd_nxt_s     = mem_wd_r;
      resp_valid_nxt_s = 1'b0;
      resp_rdata_nxt_s = 32'h0000_0000;
      resp_err_nxt_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (req_err_s) begin
                  state_nxt_s      = RESP;
                  resp_valid_nxt_s = 1'b1;
                  resp_err_nxt_s   = 1'b1;
               end else begin
                  mem_a_nxt_s = {2'b00, req_addr[31:2]};
                  if (req_we && (req_size == SZ_WORD)) begin
                     state_nxt_s  = WRITE;
                     mem_we_nxt_s = 1'b1;
                     mem_wd_nxt_s = req_wdata;
                  end else begin
                     state_nxt_s = READ;
                  end
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         READ: begin
            if (we_r) begin
               state_nxt_s  = WRITE;
               mem_we_nxt_s = 1'b1;
               mem_wd_nxt_s = lane_merge(mem_rd, wdata_r, size_r, off_r);
            end else begin
               state_nxt_s      = RESP;
               resp_valid_nxt_s = 1'b1;
               resp_rdata_nxt_s = load_ext(mem_rd, size_r, uns_r, off_r);
            end
         end
         WRITE: begin
            state_nxt_s      = RESP;
            resp_valid_nxt_s = 1'b1;
         end
         RESP: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Request capture on accept.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_r    <= 1'b0;
         size_r  <= 2'b00;
         uns_r   <= 1'b0;
         off_r   <= 2'b00;
         wdata_r <= 16'h0000;
      end else if (accept_s) begin
         we_r    <= req_we;
         size_r  <= req_size;
         uns_r   <= req_unsigned;
         off_r   <= req_addr[1:0];
         wdata_r <= req_wdata[15:0];
      end
   end

   // Registered memory-port and response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_we_r     <= 1'b0;
         mem_a_r      <= 32'h0000_0000;
         mem_wd_r     <= 32'h0000_0000;
         resp_valid_r <= 1'b0;
         resp_rdata_r <= 32'h0000_0000;
         resp_err_r   <= 1'b0;
      end else begin
         mem_we_r     <= mem_we_nxt_s;
         mem_a_r      <= mem_a_nxt_s;
         mem_wd_r     <= mem_wd_nxt_s;
         resp_valid_r <= resp_valid_nxt_s;
         resp_rdata_r <= resp_rdata_nxt_s;
         resp_err_r   <= resp_err_nxt_s;
      end
   end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Self-checking bench for lsu_dmem_port: directed cases plus random traffic against
// a byte-arithmetic reference model; honours LSU_MISALIGN_TRAP_EN when defined.
module tb_lsu_dmem_port;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   logic [31:0] dmem    [0:63];
   logic [31:0] ref_mem [0:63];
   logic        bd_we = 1'b0;
   logic [5:0]  bd_idx = 6'd0;
   logic [31:0] bd_data = 32'h0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      logic [31:0] rdata;
      logic        err;
      int          writes;
      logic [31:0] wa;
      logic [31:0] wd;
   } dir_t;

   lsu_dmem_port dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   assign mem_rd = (mem_a < 32'd64) ? dmem[mem_a[5:0]] : 32'h0BAD_0BAD;

   always @(posedge clk) begin
      if (mem_we) dmem[mem_a[5:0]] <= mem_wd;
      else if (bd_we) dmem[bd_idx] <= bd_data;
   end

   // Expected outcome computed from byte-address arithmetic; updates ref_mem for stores.
   task automatic model_req(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            output int lat, output logic [31:0] rdata, output logic err,
                            output int writes, output logic [31:0] wa, output logic [31:0] wd);
      int unsigned idx, sh, mask, w, v;
      idx = addr / 4;
      err = (size == 2'd3) || (idx >= 64);
`ifdef LSU_MISALIGN_TRAP_EN
      if ((size == 2'd1) && (addr % 2 != 0)) err = 1'b1;
      if ((size == 2'd2) && (addr % 4 != 0)) err = 1'b1;
`endif
      lat = 1; rdata = 32'h0; writes = 0; wa = 32'h0; wd = 32'h0;
      if (!err) begin
         w    = ref_mem[idx];
         sh   = (size == 2'd0) ? 8 * (addr % 4) : 16 * ((addr / 2) % 2);
         mask = (size == 2'd0) ? 255 : 65535;
         if (!we) begin
            lat = 2;
            if (size == 2'd2) v = w;
            else begin
               v = (w >> sh) & mask;
               if (!uns && (v > mask / 2)) v = v | ~mask;
            end
            rdata = v;
         end else begin
            writes = 1;
            wa = idx;
            if (size == 2'd2) begin
               v = wdata; lat = 2;
            end else begin
               v = (w & ~(mask << sh)) | ((wdata & mask) << sh); lat = 3;
            end
            ref_mem[idx] = v;
            wd = v;
         end
      end
   endtask

   // Drive one request and record what the DUT did; no judging here.
   task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int wcount, output int wcyc, output logic [31:0] wa,
                          output logic [31:0] wd, output int stray);
      int w;
      lat = 0; rdata = 32'h0; err = 1'b0; wcount = 0; wcyc = 0; wa = 32'h0; wd = 32'h0; stray = 0;
      req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 8) begin
         @(negedge clk);
         w++;
      end
      if (resp_valid || mem_we) stray++;
      @(posedge clk);
      for (int c = 1; c <= 6 && lat == 0; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
         if (mem_we) begin wcount++; wcyc = c; wa = mem_a; wd = mem_wd; end
         if (resp_valid) begin lat = c; rdata = resp_rdata; err = resp_err; end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         bd_we = 1'b1;
         bd_idx = i[5:0];
         bd_data = (i == 5) ? 32'h8899AABB : $urandom;
         ref_mem[i] = bd_data;
      end
      @(negedge clk);
      bd_we = 1'b0;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got %b expected 0", req_ready); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b expected 0", mem_we); end
      checks++; if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a got %h expected 0", mem_a); end
      checks++; if (mem_wd !== 32'h0) begin errors++; $display("FAIL reset_mem_wd got %h expected 0", mem_wd); end
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b expected 0", resp_valid); end
      checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_resp_rdata got %h expected 0", resp_rdata); end
      checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b expected 0", resp_err); end
      reset = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got %b expected 1", req_ready); end
   endtask

   task automatic test_directed;
      dir_t tbl [11];
      int lat, wcount, wcyc, stray, m_lat, m_wr;
      logic [31:0] rdata, wa, wd, m_rd, m_wa, m_wd;
      logic err, m_err;
      tbl[0] = '{1'b0, 2'd0, 1'b0, 32'h15, 32'h0, 2, 32'hFFFFFFAA, 1'b0, 0, 32'h0, 32'h0};
      tbl[1] = '{1'b0, 2'd1, 1'b1, 32'h16, 32'h0, 2, 32'h00008899, 1'b0, 0, 32'h0, 32'h0};
      tbl[2] = '{1'b0, 2'd1, 1'b0, 32'h16, 32'h0, 2, 32'hFFFF8899, 1'b0, 0, 32'h0, 32'h0};
      tbl[3] = '{1'b1, 2'd0, 1'b0, 32'h17, 32'h12345677, 3, 32'h0, 1'b0, 1, 32'd5, 32'h7799AABB};
      tbl[4] = '{1'b1, 2'd2, 1'b0, 32'h100, 32'hCAFEF00D, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0};
      tbl[5] = '{1'b0, 2'd3, 1'b0, 32'h14, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
      tbl[6] = '{1'b0, 2'd1, 1'b0, 32'h15, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0};
`else
      tbl[6] = '{1'b0, 2'd1, 1'b0, 32'h15, 32'h0, 2, 32'hFFFFAABB, 1'b0, 0, 32'h0, 32'h0};
`endif
      tbl[7] = '{1'b1, 2'd2, 1'b0, 32'h14, 32'h01020304, 2, 32'h0, 1'b0, 1, 32'd5, 32'h01020304};
      tbl[8] = '{1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 2, 32'h01020304, 1'b0, 0, 32'h0, 32'h0};
      tbl[9] = '{1'b0, 2'd0, 1'b1, 32'h16, 32'h0, 2, 32'h00000002, 1'b0, 0, 32'h0, 32'h0};
`ifdef LSU_MISALIGN_TRAP_EN
      tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h16, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 32'h0};
`else
      tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h16, 32'h0, 2, 32'h01020304, 1'b0, 0, 32'h0, 32'h0};
`endif
      for (int i = 0; i < 11; i++) begin
         model_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                   m_lat, m_rd, m_err, m_wr, m_wa, m_wd);
         run_req(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                 lat, rdata, err, wcount, wcyc, wa, wd, stray);
         checks++; if (lat !== tbl[i].lat) begin errors++; $display("FAIL directed[%0d] latency got %0d expected %0d", i, lat, tbl[i].lat); end
         checks++; if (rdata !== tbl[i].rdata) begin errors++; $display("FAIL directed[%0d] rdata got %h expected %h", i, rdata, tbl[i].rdata); end
         checks++; if (err !== tbl[i].err) begin errors++; $display("FAIL directed[%0d] err got %b expected %b", i, err, tbl[i].err); end
         checks++; if (wcount !== tbl[i].writes) begin errors++; $display("FAIL directed[%0d] write_count got %0d expected %0d", i, wcount, tbl[i].writes); end
         if (tbl[i].writes == 1) begin
            checks++; if (wcyc !== tbl[i].lat - 1) begin errors++; $display("FAIL directed[%0d] write_cycle got %0d expected %0d", i, wcyc, tbl[i].lat - 1); end
            checks++; if (wa !== tbl[i].wa) begin errors++; $display("FAIL directed[%0d] mem_a got %h expected %h", i, wa, tbl[i].wa); end
            checks++; if (wd !== tbl[i].wd) begin errors++; $display("FAIL directed[%0d] mem_wd got %h expected %h", i, wd, tbl[i].wd); end
         end
      end
   endtask

   task automatic test_back_to_back;
      int lat, wcount, wcyc, stray, e_lat, e_wr, r, s;
      logic [31:0] rdata, wa, wd, e_rd, e_wa, e_wd, addr, wdata;
      logic err, e_err, we, uns;
      logic [1:0] size;
      for (int n = 0; n < 200; n++) begin
         we = 1'($urandom_range(0, 1));
         uns = 1'($urandom_range(0, 1));
         s = int'($urandom_range(0, 7));
         size = (s == 7) ? 2'd3 : 2'(s % 3);
         r = int'($urandom_range(0, 9));
         addr = (r == 0) ? 32'h100 + 32'($urandom_range(0, 4095)) : 32'($urandom_range(0, 255));
         wdata = $urandom;
         model_req(we, size, uns, addr, wdata, e_lat, e_rd, e_err, e_wr, e_wa, e_wd);
         run_req(we, size, uns, addr, wdata, lat, rdata, err, wcount, wcyc, wa, wd, stray);
         checks++; if (lat !== e_lat) begin errors++; $display("FAIL random[%0d] latency addr=%h size=%0d we=%b got %0d expected %0d", n, addr, size, we, lat, e_lat); end
         checks++; if (rdata !== e_rd) begin errors++; $display("FAIL random[%0d] rdata addr=%h size=%0d got %h expected %h", n, addr, size, rdata, e_rd); end
         checks++; if (err !== e_err) begin errors++; $display("FAIL random[%0d] err addr=%h size=%0d got %b expected %b", n, addr, size, err, e_err); end
         checks++; if (wcount !== e_wr) begin errors++; $display("FAIL random[%0d] write_count got %0d expected %0d", n, wcount, e_wr); end
         checks++; if (stray !== 0) begin errors++; $display("FAIL random[%0d] idle_activity got %0d expected 0", n, stray); end
         if (e_wr == 1) begin
            checks++; if (wcyc !== e_lat - 1) begin errors++; $display("FAIL random[%0d] write_cycle got %0d expected %0d", n, wcyc, e_lat - 1); end
            checks++; if (wa !== e_wa) begin errors++; $display("FAIL random[%0d] mem_a got %h expected %h", n, wa, e_wa); end
            checks++; if (wd !== e_wd) begin errors++; $display("FAIL random[%0d] mem_wd got %h expected %h", n, wd, e_wd); end
         end
      end
   endtask

   task automatic test_reset_in_write;
      int w, seen;
      req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
      req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 8) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_write_enters_write mem_we got %b expected 1", mem_we); end
      checks++; if (mem_a !== 32'd8) begin errors++; $display("FAIL rst_write_mem_a got %h expected 8", mem_a); end
      reset = 1'b1;
      #1;
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rst_write_gated mem_we got %b expected 0", mem_we); end
      seen = 0;
      @(posedge clk);
      @(negedge clk);
      if (resp_valid) seen++;
      checks++; if (dmem[8] !== ref_mem[8]) begin errors++; $display("FAIL rst_write_word8 got %h expected %h", dmem[8], ref_mem[8]); end
      reset = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_write_req_ready got %b expected 1", req_ready); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rst_write_no_resp got %0d pulses expected 0", seen); end
   endtask

   task automatic test_memory_image;
      @(negedge clk);
      for (int i = 0; i < 64; i++) begin
         checks++;
         if (dmem[i] !== ref_mem[i]) begin
            errors++;
            $display("FAIL mem_image[%0d] got %h expected %h", i, dmem[i], ref_mem[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_in_write();
      test_memory_image();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
